// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the FFT bit-reversal reorder buffer.
// The master side is the FFT core and sink; the slave side is the buffer.
interface fft_bitrev_reorder_if #(
    parameter int N = 8
);
    logic [N-1:0] in_r;
    logic [N-1:0] in_i;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_r;
    logic [N-1:0] out_i;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output in_r, in_i, in_valid, out_ready,
        input  in_ready, out_r, out_i, out_valid, out_last
    );

    modport slave (
        input  in_r, in_i, in_valid, out_ready,
        output in_ready, out_r, out_i, out_valid, out_last
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong buffer that turns bit-reversed FFT output into natural order.
// Each sample lands in its natural slot on write; reads stream bins 0..NPTS-1.
module fft_bitrev_reorder #(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input logic                 clk,
    input logic                 rst,
    fft_bitrev_reorder_if.slave bus
);
    localparam int NPTS = 1 << LOG2N;

    logic [2*N-1:0]   mem [2][NPTS];
    logic [1:0]       full;
    logic             wb;
    logic             rb;
    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;
    logic [LOG2N-1:0] waddr;
    logic [2*N-1:0]   rdata;
    logic             in_fire;
    logic             out_fire;
    logic             wdone;
    logic             rdone;
    logic [1:0]       set_full;
    logic [1:0]       clr_full;

    always_comb begin
        waddr = '0;
        for (int b = 0; b < LOG2N; b++) begin
            waddr[b] = wcnt[LOG2N-1-b];
        end
    end

    assign in_fire  = bus.in_valid && !full[wb];
    assign out_fire = bus.out_ready && full[rb];
    assign wdone    = in_fire && (&wcnt);
    assign rdone    = out_fire && (&rcnt);
    assign rdata    = mem[rb][rcnt];

    assign bus.in_ready  = !full[wb];
    assign bus.out_valid = full[rb];
    assign bus.out_last  = full[rb] && (&rcnt);
    assign bus.out_r     = full[rb] ? rdata[2*N-1:N] : '0;
    assign bus.out_i     = full[rb] ? rdata[N-1:0] : '0;

    // Set and clear can both fire in one cycle only on opposite banks.
    always_comb begin
        set_full     = '0;
        clr_full     = '0;
        set_full[wb] = wdone;
        clr_full[rb] = rdone;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            full <= (full | set_full) & ~clr_full;
            if (in_fire) begin
                wcnt <= wcnt + 1'b1;
            end
            if (wdone) begin
                wb <= ~wb;
            end
            if (out_fire) begin
                rcnt <= rcnt + 1'b1;
            end
            if (rdone) begin
                rb <= ~rb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wb][waddr] <= {bus.in_r, bus.in_i};
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: random and directed traffic against a
// frame-level queue model of natural-order reordering.
module tb_fft_bitrev_reorder;
    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int NPTS  = 1 << LOG2N;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.N(N)) bus ();

    fft_bitrev_reorder #(
        .N    (N),
        .LOG2N(LOG2N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors;
    int miscompares;

    // Outputs still owed from complete frames, and the frame being filled.
    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] part[$];

    logic [N-1:0] src_r;
    logic [N-1:0] src_i;
    int           k_in;
    bit           rnd_data;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            r = r + (((k >> b) & 1) << (LOG2N - 1 - b));
        end
        return r;
    endfunction

    task automatic next_src();
        if (rnd_data) begin
            src_r = N'($urandom);
            src_i = N'($urandom);
        end else begin
            src_r = N'(k_in % NPTS);
            src_i = N'(8'hF0 + (k_in % NPTS));
        end
    endtask

    task automatic cycle(input bit iv, input bit ordy, input bit rs);
        int  frames;
        bit  in_fire;
        bit  out_fire;
        @(negedge clk);
        frames = (exp_q.size() + NPTS - 1) / NPTS;
        check("in_ready", 32'(bus.in_ready), 32'(frames < 2));
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        check("out_last", 32'(bus.out_last), 32'(exp_q.size() % NPTS == 1));
        check("out_data", 32'({bus.out_r, bus.out_i}),
              exp_q.size() > 0 ? 32'(exp_q[0]) : 32'd0);
        rst           = rs;
        bus.in_valid  = iv;
        bus.in_r      = src_r;
        bus.in_i      = src_i;
        bus.out_ready = ordy;
        in_fire  = iv && (frames < 2);
        out_fire = ordy && (exp_q.size() > 0);
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            part.delete();
        end else begin
            if (out_fire) begin
                void'(exp_q.pop_front());
            end
            if (in_fire) begin
                part.push_back({src_r, src_i});
                k_in++;
                next_src();
                if (part.size() == NPTS) begin
                    for (int k = 0; k < NPTS; k++) begin
                        exp_q.push_back(part[rev(k)]);
                    end
                    part.delete();
                end
            end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rnd_data      = 1'b0;
        k_in          = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_i      = '0;
        bus.out_ready = 1'b0;
        next_src();
        repeat (2) @(posedge clk);

        // One ordered frame drained immediately.
        for (int c = 0; c < NPTS; c++) cycle(1, 1, 0);
        for (int c = 0; c < NPTS + 2; c++) cycle(0, 1, 0);

        // Three frames into a stalled sink, then release.
        for (int c = 0; c < 3 * NPTS; c++) cycle(1, 0, 0);
        for (int c = 0; c < 4 * NPTS; c++) cycle(1, 1, 0);
        for (int c = 0; c < 2 * NPTS; c++) cycle(0, 1, 0);

        // Streaming at full rate with random data.
        rnd_data = 1'b1;
        next_src();
        for (int c = 0; c < 10 * NPTS; c++) cycle(1, 1, 0);
        for (int c = 0; c < NPTS + 1; c++) cycle(0, 1, 0);

        // Random stalls on both sides.
        for (int c = 0; c < 400; c++) begin
            cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), 0);
        end
        for (int c = 0; c < 3 * NPTS; c++) cycle(0, 1, 0);

        // Reset while frame 1 is mid-readout and frame 2 half written.
        for (int c = 0; c < NPTS; c++) cycle(1, 0, 0);
        for (int c = 0; c < 5; c++) cycle(1, 1, 0);
        cycle(0, 0, 1);
        for (int c = 0; c < 3; c++) cycle(0, 1, 0);
        for (int c = 0; c < NPTS; c++) cycle(1, 1, 0);
        for (int c = 0; c < NPTS + 2; c++) cycle(0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
